// File: rtl/draw_port_scheduler.sv
// Single-owner scheduler for the VGA plot port: arbitrates clear / stone / cursor
// requests and generates the rectangular pixel sweeps through a one-stage output pipeline.
module draw_port_scheduler #(
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120,
  parameter int STONE_SIZE = 7,
  parameter int CUR_SIZE   = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        clr_req,
  input  logic        stn_req,
  input  logic [7:0]  stn_x,
  input  logic [6:0]  stn_y,
  input  logic [2:0]  stn_colour,
  input  logic        cur_req,
  input  logic [7:0]  cur_x,
  input  logic [6:0]  cur_y,
  input  logic [2:0]  cur_colour,
  output logic [14:0] bg_address,
  input  logic [2:0]  bg_q,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        plot,
  output logic        clr_done,
  output logic        stn_done,
  output logic        cur_done,
  output logic        busy
);

  localparam logic [7:0]  CLR_W     = 8'(SCREEN_W);
  localparam logic [6:0]  CLR_H     = 7'(SCREEN_H);
  localparam logic [7:0]  STN_W     = 8'(STONE_SIZE);
  localparam logic [6:0]  STN_H     = 7'(STONE_SIZE);
  localparam logic [7:0]  CUR_W     = 8'(CUR_SIZE);
  localparam logic [6:0]  CUR_H     = 7'(CUR_SIZE);
  localparam logic [8:0]  LIM_X     = 9'(SCREEN_W);
  localparam logic [7:0]  LIM_Y     = 8'(SCREEN_H);
  localparam logic [14:0] ROW_PITCH = 15'(SCREEN_W);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_STN, S_CUR_ERASE, S_CUR_DRAW
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  x_cnt_q, x_cnt_d;
  logic [6:0]  y_cnt_q, y_cnt_d;
  logic [7:0]  org_x_q, org_x_d;
  logic [6:0]  org_y_q, org_y_d;
  logic [2:0]  colour_q, colour_d;
  logic [7:0]  new_x_q, new_x_d;
  logic [6:0]  new_y_q, new_y_d;
  logic [7:0]  old_x_q, old_x_d;
  logic [6:0]  old_y_q, old_y_d;
  logic        cur_valid_q, cur_valid_d;
  logic [7:0]  vga_x_q, vga_x_d;
  logic [6:0]  vga_y_q, vga_y_d;
  logic        plot_q, plot_d;
  logic        use_bg_q, use_bg_d;
  logic [2:0]  pix_colour_q, pix_colour_d;
  logic        clr_done_q, clr_done_d;
  logic        stn_done_q, stn_done_d;
  logic        cur_done_q, cur_done_d;

  logic        sweep;
  logic [7:0]  span_w;
  logic [6:0]  span_h;
  logic [8:0]  pix_x;
  logic [7:0]  pix_y;
  logic        in_bounds;
  logic        last_x;
  logic        last_y;
  logic [14:0] pix_addr;

  assign sweep     = (state_q != S_IDLE);
  assign pix_x     = {1'b0, org_x_q} + {1'b0, x_cnt_q};
  assign pix_y     = {1'b0, org_y_q} + {1'b0, y_cnt_q};
  assign in_bounds = (pix_x < LIM_X) && (pix_y < LIM_Y);
  assign pix_addr  = 15'(pix_x) + 15'(pix_y) * ROW_PITCH;
  assign last_x    = (x_cnt_q == span_w - 8'd1);
  assign last_y    = (y_cnt_q == span_h - 7'd1);

  always_comb begin
    span_w = CUR_W;
    span_h = CUR_H;
    case (state_q)
      S_CLR: begin span_w = CLR_W; span_h = CLR_H; end
      S_STN: begin span_w = STN_W; span_h = STN_H; end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    x_cnt_d      = x_cnt_q;
    y_cnt_d      = y_cnt_q;
    org_x_d      = org_x_q;
    org_y_d      = org_y_q;
    colour_d     = colour_q;
    new_x_d      = new_x_q;
    new_y_d      = new_y_q;
    old_x_d      = old_x_q;
    old_y_d      = old_y_q;
    cur_valid_d  = cur_valid_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    plot_d       = 1'b0;
    use_bg_d     = use_bg_q;
    pix_colour_d = pix_colour_q;
    clr_done_d   = 1'b0;
    stn_done_d   = 1'b0;
    cur_done_d   = 1'b0;

    if (state_q == S_IDLE) begin
      x_cnt_d = '0;
      y_cnt_d = '0;
      if (clr_req) begin
        state_d = S_CLR;
        org_x_d = '0;
        org_y_d = '0;
      end else if (stn_req) begin
        state_d  = S_STN;
        org_x_d  = stn_x;
        org_y_d  = stn_y;
        colour_d = stn_colour;
      end else if (cur_req) begin
        new_x_d  = cur_x;
        new_y_d  = cur_y;
        colour_d = cur_colour;
        // An on-screen cursor must be restored from background before redrawing
        if (cur_valid_q) begin
          state_d = S_CUR_ERASE;
          org_x_d = old_x_q;
          org_y_d = old_y_q;
        end else begin
          state_d = S_CUR_DRAW;
          org_x_d = cur_x;
          org_y_d = cur_y;
        end
      end
    end else begin
      plot_d       = in_bounds;
      vga_x_d      = pix_x[7:0];
      vga_y_d      = pix_y[6:0];
      use_bg_d     = (state_q == S_CLR) || (state_q == S_CUR_ERASE);
      pix_colour_d = colour_q;

      if (!last_x) begin
        x_cnt_d = x_cnt_q + 8'd1;
      end else begin
        x_cnt_d = '0;
        if (!last_y) begin
          y_cnt_d = y_cnt_q + 7'd1;
        end else begin
          y_cnt_d = '0;
          case (state_q)
            S_CLR: begin
              state_d     = S_IDLE;
              clr_done_d  = 1'b1;
              cur_valid_d = 1'b0;
            end
            S_STN: begin
              state_d    = S_IDLE;
              stn_done_d = 1'b1;
            end
            S_CUR_ERASE: begin
              state_d = S_CUR_DRAW;
              org_x_d = new_x_q;
              org_y_d = new_y_q;
            end
            default: begin
              state_d     = S_IDLE;
              cur_done_d  = 1'b1;
              cur_valid_d = 1'b1;
              old_x_d     = new_x_q;
              old_y_d     = new_y_q;
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      x_cnt_q      <= '0;
      y_cnt_q      <= '0;
      org_x_q      <= '0;
      org_y_q      <= '0;
      colour_q     <= '0;
      new_x_q      <= '0;
      new_y_q      <= '0;
      old_x_q      <= '0;
      old_y_q      <= '0;
      cur_valid_q  <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      plot_q       <= 1'b0;
      use_bg_q     <= 1'b0;
      pix_colour_q <= '0;
      clr_done_q   <= 1'b0;
      stn_done_q   <= 1'b0;
      cur_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_cnt_q      <= x_cnt_d;
      y_cnt_q      <= y_cnt_d;
      org_x_q      <= org_x_d;
      org_y_q      <= org_y_d;
      colour_q     <= colour_d;
      new_x_q      <= new_x_d;
      new_y_q      <= new_y_d;
      old_x_q      <= old_x_d;
      old_y_q      <= old_y_d;
      cur_valid_q  <= cur_valid_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      plot_q       <= plot_d;
      use_bg_q     <= use_bg_d;
      pix_colour_q <= pix_colour_d;
      clr_done_q   <= clr_done_d;
      stn_done_q   <= stn_done_d;
      cur_done_q   <= cur_done_d;
    end
  end

  // Background pixels take their colour from the ROM word returned one cycle after the address
  assign bg_address = sweep ? pix_addr : '0;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = use_bg_q ? bg_q : pix_colour_q;
  assign plot       = plot_q;
  assign clr_done   = clr_done_q;
  assign stn_done   = stn_done_q;
  assign cur_done   = cur_done_q;
  assign busy       = sweep;

endmodule

// File: tb/tb_draw_port_scheduler.sv
// Bench for draw_port_scheduler: a pixel-list model of each job (clear, stone, cursor)
// is compared against the plots, done pulses and addresses seen on the DUT ports.
module tb_draw_port_scheduler;

  logic        clk = 1'b0;
  logic        resetn;
  logic        clr_req, stn_req, cur_req;
  logic [7:0]  stn_x, cur_x;
  logic [6:0]  stn_y, cur_y;
  logic [2:0]  stn_colour, cur_colour;
  logic [14:0] bg_address;
  logic [2:0]  bg_q = 3'd0;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        plot, clr_done, stn_done, cur_done, busy;

  draw_port_scheduler dut (
    .clk(clk), .resetn(resetn),
    .clr_req(clr_req),
    .stn_req(stn_req), .stn_x(stn_x), .stn_y(stn_y), .stn_colour(stn_colour),
    .cur_req(cur_req), .cur_x(cur_x), .cur_y(cur_y), .cur_colour(cur_colour),
    .bg_address(bg_address), .bg_q(bg_q),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .plot(plot),
    .clr_done(clr_done), .stn_done(stn_done), .cur_done(cur_done), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam int K_CLR = 0;
  localparam int K_STN = 1;
  localparam int K_CUR = 2;

  // Background image: an arbitrary but address-sensitive pattern
  function automatic logic [2:0] bg_rom(input int a);
    logic [14:0] v;
    v = a[14:0];
    return v[2:0] ^ v[5:3] ^ v[10:8] ^ v[13:11];
  endfunction

  int cyc = 0;
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    bg_q <= bg_rom(int'(bg_address));
  end

  typedef struct { int x; int y; int c; int at; } pix_t;
  typedef struct { int kind; int at; int busy; } done_t;

  pix_t  exp_pix[$];
  pix_t  obs_pix[$];
  done_t exp_done[$];
  done_t obs_done[$];
  int    addr_log[$];

  int n_assert = 0;
  int n_fail   = 0;

  bit cur_valid_m;
  int old_x_m, old_y_m;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One cycle: sample on the falling edge; "at" is the rising edge that would capture it.
  task automatic step();
    pix_t  p;
    done_t d;
    @(negedge clk);
    if (plot === 1'b1) begin
      p.x = int'(vga_x); p.y = int'(vga_y); p.c = int'(vga_colour); p.at = cyc + 1;
      obs_pix.push_back(p);
    end
    if (busy === 1'b1) addr_log.push_back(int'(bg_address));
    d.at = cyc + 1;
    d.busy = int'(busy);
    if (clr_done === 1'b1) begin d.kind = K_CLR; obs_done.push_back(d); clr_req = 1'b0; end
    if (stn_done === 1'b1) begin d.kind = K_STN; obs_done.push_back(d); stn_req = 1'b0; end
    if (cur_done === 1'b1) begin d.kind = K_CUR; obs_done.push_back(d); cur_req = 1'b0; end
  endtask

  task automatic model_rect(input int ox, input int oy, input int w, input int h,
                            input int g, input bit use_bg, input int col);
    pix_t p;
    for (int dy = 0; dy < h; dy++) begin
      for (int dx = 0; dx < w; dx++) begin
        p.x = ox + dx;
        p.y = oy + dy;
        if (p.x < 160 && p.y < 120) begin
          p.c  = use_bg ? int'(bg_rom(p.x + p.y * 160)) : col;
          p.at = g + 2 + dy * w + dx;
          exp_pix.push_back(p);
        end
      end
    end
  endtask

  // g = edge at which the request is granted; returns the edge carrying the done pulse
  task automatic model_job(input int kind, input int g, input int x, input int y,
                           input int col, output int done_at);
    done_t d;
    case (kind)
      K_CLR: begin
        model_rect(0, 0, 160, 120, g, 1'b1, 0);
        done_at = g + 1 + 19200;
        cur_valid_m = 1'b0;
      end
      K_STN: begin
        model_rect(x, y, 7, 7, g, 1'b0, col);
        done_at = g + 1 + 49;
      end
      default: begin
        if (cur_valid_m) begin
          model_rect(old_x_m, old_y_m, 3, 3, g, 1'b1, 0);
          model_rect(x, y, 3, 3, g + 9, 1'b0, col);
          done_at = g + 1 + 18;
        end else begin
          model_rect(x, y, 3, 3, g, 1'b0, col);
          done_at = g + 1 + 9;
        end
        cur_valid_m = 1'b1;
        old_x_m = x;
        old_y_m = y;
      end
    endcase
    d.kind = kind; d.at = done_at; d.busy = 0;
    exp_done.push_back(d);
  endtask

  task automatic compare(input string tag);
    int bad;
    int n;
    bad = -1;
    chk($sformatf("%s_nplots", tag), obs_pix.size(), exp_pix.size());
    n = (obs_pix.size() < exp_pix.size()) ? obs_pix.size() : exp_pix.size();
    for (int i = 0; i < n; i++) begin
      if (obs_pix[i].x != exp_pix[i].x || obs_pix[i].y != exp_pix[i].y ||
          obs_pix[i].c != exp_pix[i].c || obs_pix[i].at != exp_pix[i].at) begin
        bad = i;
        break;
      end
    end
    if (bad >= 0)
      $display("  %s pixel %0d: got (%0d,%0d) c=%0d @%0d, want (%0d,%0d) c=%0d @%0d", tag, bad,
               obs_pix[bad].x, obs_pix[bad].y, obs_pix[bad].c, obs_pix[bad].at,
               exp_pix[bad].x, exp_pix[bad].y, exp_pix[bad].c, exp_pix[bad].at);
    chk($sformatf("%s_first_bad_pixel", tag), bad, -1);
    chk($sformatf("%s_ndone", tag), obs_done.size(), exp_done.size());
    n = (obs_done.size() < exp_done.size()) ? obs_done.size() : exp_done.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_done%0d_kind", tag, i), obs_done[i].kind, exp_done[i].kind);
      chk($sformatf("%s_done%0d_edge", tag, i), obs_done[i].at, exp_done[i].at);
      chk($sformatf("%s_done%0d_busy", tag, i), obs_done[i].busy, 0);
    end
    $display("%s: %0d plots, %0d done pulses", tag, obs_pix.size(), obs_done.size());
    exp_pix.delete(); obs_pix.delete(); exp_done.delete(); obs_done.delete(); addr_log.delete();
  endtask

  task automatic run(input string tag, input int n_done, input int budget);
    int t;
    t = 0;
    while (obs_done.size() < n_done && t < budget) begin
      step();
      t++;
    end
    chk($sformatf("%s_in_budget", tag), (obs_done.size() >= n_done), 1);
    clr_req = 1'b0; stn_req = 1'b0; cur_req = 1'b0;
    repeat (3) step();
  endtask

  // Raises one held request at the current falling edge; grant lands on the next rising edge
  task automatic do_job(input string tag, input int kind, input int x, input int y, input int col);
    int g, d;
    g = cyc + 1;
    if (kind == K_STN) begin
      stn_x = 8'(x); stn_y = 7'(y); stn_colour = 3'(col); stn_req = 1'b1;
    end else begin
      cur_x = 8'(x); cur_y = 7'(y); cur_colour = 3'(col); cur_req = 1'b1;
    end
    model_job(kind, g, x, y, col, d);
    run(tag, 1, 200);
    compare(tag);
  endtask

  initial begin
    int g, d1, d2, d3;
    resetn = 1'b0;
    clr_req = 1'b0; stn_req = 1'b0; cur_req = 1'b0;
    stn_x = '0; stn_y = '0; stn_colour = '0;
    cur_x = '0; cur_y = '0; cur_colour = '0;
    cur_valid_m = 1'b0; old_x_m = 0; old_y_m = 0;
    repeat (3) @(negedge clk);
    chk("rst_plot", plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_clr_done", clr_done, 0);
    chk("rst_stn_done", stn_done, 0);
    chk("rst_cur_done", cur_done, 0);
    chk("rst_vga_x", vga_x, 0);
    chk("rst_vga_y", vga_y, 0);
    chk("rst_vga_colour", vga_colour, 0);
    chk("rst_bg_address", bg_address, 0);
    resetn = 1'b1;
    repeat (2) step();

    // Full clear with a one-cycle request
    g = cyc + 1;
    clr_req = 1'b1;
    model_job(K_CLR, g, 0, 0, 0, d1);
    step();
    clr_req = 1'b0;
    run("clr", 1, 20000);
    chk("clr_naddr", addr_log.size(), 19200);
    chk("clr_first_addr", (addr_log.size() > 0) ? addr_log[0] : -1, 0);
    chk("clr_last_addr", (addr_log.size() > 0) ? addr_log[addr_log.size() - 1] : -1, 19199);
    compare("clr");

    do_job("stn_10_20", K_STN, 10, 20, 7);
    do_job("cur_50_40", K_CUR, 50, 40, 5);
    do_job("cur_52_40", K_CUR, 52, 40, 2);
    do_job("stn_clip", K_STN, 157, 117, 6);

    for (int i = 0; i < 14; i++) begin
      int kind;
      kind = (($urandom_range(0, 1)) == 0) ? K_STN : K_CUR;
      do_job($sformatf("rand%0d", i), kind, int'($urandom_range(0, 159)),
             int'($urandom_range(0, 119)), int'($urandom_range(0, 7)));
    end

    // All three requesters at once, each held until its own done pulse
    g = cyc + 1;
    stn_x = 8'd30; stn_y = 7'd60; stn_colour = 3'd4;
    cur_x = 8'd90; cur_y = 7'd100; cur_colour = 3'd1;
    clr_req = 1'b1; stn_req = 1'b1; cur_req = 1'b1;
    model_job(K_CLR, g, 0, 0, 0, d1);
    model_job(K_STN, d1, 30, 60, 4, d2);
    model_job(K_CUR, d2, 90, 100, 1, d3);
    run("multi", 3, 20000);
    compare("multi");

    // Reset during a clear aborts it silently and forgets the cursor
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (300) step();
    #2 resetn = 1'b0;
    #1;
    chk("abort_plot", plot, 0);
    chk("abort_busy", busy, 0);
    obs_pix.delete(); obs_done.delete(); addr_log.delete();
    cur_valid_m = 1'b0; old_x_m = 0; old_y_m = 0;
    repeat (3) step();
    resetn = 1'b1;
    repeat (3) step();
    chk("abort_no_done", obs_done.size(), 0);
    chk("abort_no_plot", obs_pix.size(), 0);
    do_job("cur_after_abort", K_CUR, 70, 30, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/draw_port_scheduler.md
Name: draw_port_scheduler

Overview:
- Owns the single VGA plot port and shares it between three requesters: full-board clear, stone draw and cursor move.
- Generates the pixel sweeps itself: background restore over the full 160x120 screen, and rectangular boxes for stones and the cursor.
- Sequences each cursor move as erase-old-position, then draw-new-position.
- Sits between the game FSM / mouse logic and the vga_adapter, with the background ROM on its read side.

Parameters:
- SCREEN_W, 160, screen width in pixels.
- SCREEN_H, 120, screen height in pixels.
- STONE_SIZE, 7, stone box edge in pixels.
- CUR_SIZE, 3, cursor box edge in pixels.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- clr_req  in  1  level request: restore the whole screen from background.
- stn_req  in  1  level request: draw a stone.
- stn_x  in  8  stone box top-left x.
- stn_y  in  7  stone box top-left y.
- stn_colour  in  3  stone colour.
- cur_req  in  1  level request: move the cursor.
- cur_x  in  8  new cursor top-left x.
- cur_y  in  7  new cursor top-left y.
- cur_colour  in  3  cursor colour.
- bg_address  out  15  background ROM address.
- bg_q  in  3  background ROM data, valid 1 cycle after bg_address.
- vga_x  out  8  plot x.
- vga_y  out  7  plot y.
- vga_colour  out  3  plot colour.
- plot  out  1  write strobe to vga_adapter.
- clr_done  out  1  1-cycle pulse when the clear completes.
- stn_done  out  1  1-cycle pulse when the stone draw completes.
- cur_done  out  1  1-cycle pulse when the cursor move completes.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: asynchronous and active-low.
  - All outputs 0, state IDLE, counters 0.
  - cur_valid=0 (no cursor on screen); stored old cursor position 0,0.
  - Reset mid-sweep aborts the sweep immediately; no done pulse is issued.
- States: IDLE, CLR, STN, CUR_ERASE, CUR_DRAW.
- Arbitration: requests are sampled only in IDLE, fixed priority clr > stn > cur.
  - On grant, the block latches the granting request's x/y/colour.
  - A requester may drop req after seeing busy; a req still high after its done pulse is re-granted.
  - A losing request stays pending and is served on a later IDLE cycle.
- Sweep counters: x-inner, y-outer.
  - CLR sweeps 0..159 by 0..119 (19200 pixels).
  - STN sweeps STONE_SIZE^2 pixels; CUR_* states sweep CUR_SIZE^2 pixels, each from the latched origin.
- Address: bg_address = x + y*160, computed at 15 bits and driven every cycle in a sweep state.
- Pipeline: 1 stage.
  - The pixel generated in cycle k appears on vga_x/vga_y/plot in cycle k+1.
  - vga_colour in k+1 is bg_q for CLR and CUR_ERASE, and the latched colour for STN and CUR_DRAW.
- Clipping: pixels with x>=160 or y>=120 are swept but produce plot=0.
  - Such pixels still consume a cycle.
  - The address for clipped pixels is don't-care.
- Sweep completion: after the last pixel is generated the state returns to IDLE.
  - That IDLE cycle carries the final plot and the done pulse together.
  - A new grant may be taken in that same IDLE cycle.
- Cursor path:
  - If cur_valid=1, run CUR_ERASE at the stored old position first, then CUR_DRAW at the new position.
  - If cur_valid=0, go straight to CUR_DRAW.
  - On CUR_DRAW completion: store the new position and set cur_valid=1.
  - Completion of CLR clears cur_valid, since the background restore already erased the cursor.
- STN never touches cur_valid or the stored cursor position.
  - A stone drawn over the cursor is overwritten by the next CUR_ERASE. This is accepted.
- Latency:
  - clr_req sampled at edge N: first plot at N+2, last plot and clr_done at N+19201.
  - Stone: done at N+1+STONE_SIZE^2.
  - Cursor with cur_valid=1: done at N+1+2*CUR_SIZE^2, with no gap cycle between erase and draw.
- plot is never high outside the cycle following a sweep-state cycle.

Test Plan:
- Reset, then clr_req for 1 cycle at edge N:
  - exactly 19200 plot pulses, from N+2 to N+19201.
  - Pixel (0,0) comes first with bg_address 0; pixel (159,119) comes last with bg_address 19199.
  - Colour equals bg_q delayed 1 cycle; clr_done is high only at N+19201.
- stn_req with (10,20), colour 3'b111:
  - 49 plots covering x 10..16, y 20..26, all colour 7.
  - stn_done fires at N+50; busy falls the same cycle.
- cur_req (50,40) after reset: 9 plots with cur_colour only (no erase).
  - A second cur_req (52,40) then gives 9 erase plots at x 50..52 with background colour, followed immediately by 9 draw plots at x 52..54.
  - cur_done fires once.
- clr_req, stn_req and cur_req raised in the same cycle and held:
  - order of service is CLR, STN, CUR.
  - The cursor skips erase because CLR cleared cur_valid.
- stn_req at (157,117), STONE_SIZE=7:
  - only the 9 pixels with x 157..159 and y 117..119 plot.
  - stn_done still fires at N+50.
- resetn pulled low mid-CLR:
  - plot drops immediately and no clr_done is issued.
  - After release, a fresh cur_req draws without erase.
